tx_fifo_arb: RTL and testbench

TX_FIFO_ARB -- requirements
Module: tx_fifo_arb

---
 rtl/tx_fifo_arb_pkg.sv | 19 +
 rtl/tx_fifo_arb_rr_arb2.sv | 21 ++
 rtl/tx_fifo_arb.sv | 107 ++++++++++
 tb/tb_tx_fifo_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_arb_pkg.sv
// Shared types and constants for the TX FIFO arbiter: FSM states, source IDs
// and the reset value of the last-grant register.
package tx_fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_B0 = 2'd1,
    SEND_B1 = 2'd2
  } state_t;

  typedef enum logic {
    SRC_RF  = 1'b0,
    SRC_ALU = 1'b1
  } src_t;

  // Pretending ALU won last makes the first tie after reset go to RF.
  localparam src_t LAST_GRANT_RST = SRC_ALU;

endpackage

// File: rtl/tx_fifo_arb_rr_arb2.sv
// Two-way round-robin arbiter: req[0] = RF, req[1] = ALU; on a tie the
// requester that did not win last time gets the one-hot grant.
module rr_arb2
  import tx_fifo_arb_pkg::*;
(
  input  logic [1:0] req,
  input  src_t       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == SRC_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/tx_fifo_arb.sv
// Arbitrates RF (1 byte) and ALU (2 byte) results into a FIFO write port.
// Define TX_FIFO_ARB_MSB_FIRST_EN to send ALU results upper byte first.
//
// Handshake: a requester holds REQ (with stable data) until it samples its
// ACK high; ACK is a one-cycle registered pulse the cycle after capture, and
// the requester drops or renews REQ on the edge that samples it. The FIFO
// side writes a byte on every cycle FIFO_W_INC is high.
module tx_fifo_arb
  import tx_fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RF_REQ,
  input  logic [DATA_WIDTH-1:0]   RF_DATA,
  output logic                    RF_ACK,
  input  logic                    ALU_REQ,
  input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
  output logic                    ALU_ACK,
  input  logic                    FIFO_FULL,
  output logic                    FIFO_W_INC,
  output logic [DATA_WIDTH-1:0]   FIFO_W_DATA,
  output logic                    BUSY
);

  localparam int W = DATA_WIDTH;

  state_t           state_q, state_d;
  src_t             src_q, src_d;
  src_t             last_q, last_d;
  logic [2*W-1:0]   hold_q, hold_d;
  logic             rf_ack_q, rf_ack_d;
  logic             alu_ack_q, alu_ack_d;
  logic [1:0]       grant;
  logic [2*W-1:0]   alu_hold;
  logic             write_ok;

  rr_arb2 u_rr_arb2 (
    .req   ({ALU_REQ, RF_REQ}),
    .last  (last_q),
    .grant (grant)
  );

  // Byte order is fixed at capture so SEND_B0 always sends the low half.
`ifdef TX_FIFO_ARB_MSB_FIRST_EN
  assign alu_hold = {ALU_DATA[W-1:0], ALU_DATA[2*W-1:W]};
`else
  assign alu_hold = ALU_DATA;
`endif

  // Gated by RST so a reset mid-transaction never emits a stray byte.
  assign write_ok = (state_q != IDLE) && !FIFO_FULL && !RST;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    last_d    = last_q;
    hold_d    = hold_q;
    rf_ack_d  = 1'b0;
    alu_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          src_d     = grant[1] ? SRC_ALU : SRC_RF;
          last_d    = src_d;
          hold_d    = grant[1] ? alu_hold : {{W{1'b0}}, RF_DATA};
          rf_ack_d  = grant[0];
          alu_ack_d = grant[1];
          state_d   = SEND_B0;
        end
      end
      SEND_B0: begin
        if (write_ok) state_d = (src_q == SRC_ALU) ? SEND_B1 : IDLE;
      end
      SEND_B1: begin
        if (write_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      src_q     <= SRC_RF;
      last_q    <= LAST_GRANT_RST;
      hold_q    <= '0;
      rf_ack_q  <= 1'b0;
      alu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rf_ack_q  <= rf_ack_d;
      alu_ack_q <= alu_ack_d;
    end
  end

  assign RF_ACK      = rf_ack_q;
  assign ALU_ACK     = alu_ack_q;
  assign BUSY        = (state_q != IDLE);
  assign FIFO_W_INC  = write_ok;
  assign FIFO_W_DATA = (state_q == SEND_B1) ? hold_q[2*W-1:W] : hold_q[W-1:0];

endmodule

// File: tb/tb_tx_fifo_arb.sv
// Self-checking bench for tx_fifo_arb: expected FIFO bytes are queued when a
// request is driven and popped by a monitor on every observed write strobe.
module tb_tx_fifo_arb;
  import tx_fifo_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RF_REQ = 1'b0;
  logic [7:0]  RF_DATA = '0;
  logic        RF_ACK;
  logic        ALU_REQ = 1'b0;
  logic [15:0] ALU_DATA = '0;
  logic        ALU_ACK;
  logic        FIFO_FULL = 1'b0;
  logic        FIFO_W_INC;
  logic [7:0]  FIFO_W_DATA;
  logic        BUSY;

  int total = 0;
  int bad = 0;
  int wr_n = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  src_t last_g = LAST_GRANT_RST;
  bit rand_done = 1'b0;

  tx_fifo_arb #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .RF_REQ(RF_REQ), .RF_DATA(RF_DATA), .RF_ACK(RF_ACK),
    .ALU_REQ(ALU_REQ), .ALU_DATA(ALU_DATA), .ALU_ACK(ALU_ACK),
    .FIFO_FULL(FIFO_FULL), .FIFO_W_INC(FIFO_W_INC),
    .FIFO_W_DATA(FIFO_W_DATA), .BUSY(BUSY)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_first(input logic [15:0] d);
`ifdef TX_FIFO_ARB_MSB_FIRST_EN
    return d[15:8];
`else
    return d[7:0];
`endif
  endfunction

  function automatic logic [7:0] alu_second(input logic [15:0] d);
`ifdef TX_FIFO_ARB_MSB_FIRST_EN
    return d[7:0];
`else
    return d[15:8];
`endif
  endfunction

  // scoreboard monitor
  always @(negedge CLK) begin
    if (FIFO_W_INC === 1'b1) begin
      wr_n++;
      if (exp_q.size() == 0) begin
        check("unexp_wr", {24'd0, FIFO_W_DATA}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr_data", {24'd0, FIFO_W_DATA}, {24'd0, mon_exp});
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    RST = 1'b1; RF_REQ = 1'b0; ALU_REQ = 1'b0; FIFO_FULL = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    last_g = LAST_GRANT_RST;
  endtask

  task automatic rf_send(input logic [7:0] d);
    bit got = 1'b0;
    RF_DATA = d;
    RF_REQ = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (RF_ACK) got = 1'b1;
    end
    check("rf_ack_seen", {31'd0, got}, 32'd1);
    @(posedge CLK);
    #1 RF_REQ = 1'b0;
  endtask

  task automatic alu_send(input logic [15:0] d);
    bit got = 1'b0;
    ALU_DATA = d;
    ALU_REQ = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (ALU_ACK) got = 1'b1;
    end
    check("alu_ack_seen", {31'd0, got}, 32'd1);
    @(posedge CLK);
    #1 ALU_REQ = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge CLK);
      if (!BUSY) done = 1'b1;
    end
    check("idle_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_first_write();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (FIFO_W_INC) seen = 1'b1;
    end
    check("b0_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic xact_rf(input logic [7:0] d);
    @(posedge CLK); #1;
    exp_q.push_back(d);
    last_g = SRC_RF;
    rf_send(d);
    wait_idle();
  endtask

  task automatic xact_alu(input logic [15:0] d);
    @(posedge CLK); #1;
    exp_q.push_back(alu_first(d));
    exp_q.push_back(alu_second(d));
    last_g = SRC_ALU;
    alu_send(d);
    wait_idle();
  endtask

  // Tie: the model grants whoever did not win last, then the other one.
  task automatic xact_tie(input logic [7:0] r, input logic [15:0] a);
    @(posedge CLK); #1;
    if (last_g == SRC_ALU) begin
      exp_q.push_back(r);
      exp_q.push_back(alu_first(a));
      exp_q.push_back(alu_second(a));
      last_g = SRC_ALU;
    end else begin
      exp_q.push_back(alu_first(a));
      exp_q.push_back(alu_second(a));
      exp_q.push_back(r);
      last_g = SRC_RF;
    end
    fork
      rf_send(r);
      alu_send(a);
    join
    wait_idle();
  endtask

  initial begin
    int w0;
    int ack_n;
    int winc_n;
    do_reset();

    // reset state
    @(negedge CLK);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_rf_ack", {31'd0, RF_ACK}, 32'd0);
    check("rst_alu_ack", {31'd0, ALU_ACK}, 32'd0);
    check("rst_winc", {31'd0, FIFO_W_INC}, 32'd0);
    check("rst_wdata", {24'd0, FIFO_W_DATA}, 32'd0);

    // single RF byte, cycle-accurate
    @(posedge CLK); #1;
    exp_q.push_back(8'hA5);
    RF_DATA = 8'hA5;
    RF_REQ = 1'b1;
    @(negedge CLK);
    check("rf_pre_busy", {31'd0, BUSY}, 32'd0);
    check("rf_pre_ack", {31'd0, RF_ACK}, 32'd0);
    @(negedge CLK);
    check("rf_ack", {31'd0, RF_ACK}, 32'd1);
    check("rf_busy", {31'd0, BUSY}, 32'd1);
    check("rf_winc", {31'd0, FIFO_W_INC}, 32'd1);
    check("rf_wdata", {24'd0, FIFO_W_DATA}, 32'hA5);
    @(posedge CLK); #1 RF_REQ = 1'b0;
    @(negedge CLK);
    check("rf_post_ack", {31'd0, RF_ACK}, 32'd0);
    check("rf_post_busy", {31'd0, BUSY}, 32'd0);
    check("rf_post_winc", {31'd0, FIFO_W_INC}, 32'd0);
    last_g = SRC_RF;

    // ALU two bytes back to back
    w0 = wr_n;
    xact_alu(16'h1234);
    check("alu_wr_cnt", wr_n - w0, 32'd2);

    // ties after reset: RF first, then after an RF win the ALU goes first
    do_reset();
    xact_tie(8'h11, 16'hBEEF);
    xact_rf(8'h22);
    xact_tie(8'h33, 16'h4455);
    xact_tie(8'h66, 16'h7788);

    // FIFO full for 3 cycles during SEND_B1
    @(posedge CLK); #1;
    w0 = wr_n;
    exp_q.push_back(alu_first(16'hCAFE));
    exp_q.push_back(alu_second(16'hCAFE));
    last_g = SRC_ALU;
    fork
      alu_send(16'hCAFE);
      begin
        wait_first_write();
        @(posedge CLK); #1 FIFO_FULL = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge CLK);
          check("full_winc", {31'd0, FIFO_W_INC}, 32'd0);
          check("full_busy", {31'd0, BUSY}, 32'd1);
        end
        @(posedge CLK); #1 FIFO_FULL = 1'b0;
        @(negedge CLK);
        check("b1_winc", {31'd0, FIFO_W_INC}, 32'd1);
      end
    join
    wait_idle();
    check("full_wr_cnt", wr_n - w0, 32'd2);

    // reset in SEND_B1 abandons the second byte
    @(posedge CLK); #1;
    w0 = wr_n;
    exp_q.push_back(alu_first(16'h5566));
    fork
      alu_send(16'h5566);
      begin
        wait_first_write();
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        check("rst_cyc_winc", {31'd0, FIFO_W_INC}, 32'd0);
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        check("mid_rst_rf_ack", {31'd0, RF_ACK}, 32'd0);
        check("mid_rst_alu_ack", {31'd0, ALU_ACK}, 32'd0);
        check("mid_rst_winc", {31'd0, FIFO_W_INC}, 32'd0);
        check("mid_rst_wdata", {24'd0, FIFO_W_DATA}, 32'd0);
      end
    join
    last_g = LAST_GRANT_RST;
    check("mid_rst_wr_cnt", wr_n - w0, 32'd1);
    xact_rf(8'h77);

    // FIFO stuck full: capture and one ACK, no strobe, stays busy
    @(posedge CLK); #1;
    w0 = wr_n;
    FIFO_FULL = 1'b1;
    exp_q.push_back(alu_first(16'h9A3C));
    exp_q.push_back(alu_second(16'h9A3C));
    last_g = SRC_ALU;
    ack_n = 0;
    winc_n = 0;
    fork
      alu_send(16'h9A3C);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge CLK);
          if (ALU_ACK) ack_n++;
          if (FIFO_W_INC) winc_n++;
        end
      end
    join
    check("stuck_ack_cnt", ack_n, 32'd1);
    check("stuck_winc_cnt", winc_n, 32'd0);
    check("stuck_busy", {31'd0, BUSY}, 32'd1);
    @(posedge CLK); #1 FIFO_FULL = 1'b0;
    wait_idle();
    check("stuck_wr_cnt", wr_n - w0, 32'd2);

    // random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          case ($urandom_range(0, 2))
            0: xact_rf(8'($urandom_range(0, 255)));
            1: xact_alu(16'($urandom_range(0, 65535)));
            default: xact_tie(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
          endcase
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge CLK); #1;
          FIFO_FULL = ($urandom_range(0, 3) == 0);
        end
        FIFO_FULL = 1'b0;
      end
    join
    wait_idle();

    repeat (3) @(negedge CLK);
    check("q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
